gpio_emu_mul: RTL and testbench
===============================

// Module: gpio_emu_mul
// PURPOSE
//  Memory-mapped 32x32 unsigned multiplier peripheral on the emulated GPIO/system bus.
//  Host writes two operands, writes the control register to start, polls status, then reads the 64-bit product.
//  Also provides a GPIO output mirror of the product and a latched GPIO input snapshot.
//  Sits as a slave on the system bus (saddress/srd/swr/sdata_*), one clock domain.
// PARAMETERS
//  ADDR_A1   16'h037F  operand A register (W/R)
//  ADDR_A2   16'h0388  operand B register (W/R)
//  ADDR_RES  16'h0390  product bits [31:0] (R)
//  ADDR_RESH 16'h0394  product bits [63:32] (R)
//  ADDR_STAT 16'h0398  status: bit0 busy, bit1 done (R)
//  ADDR_CTRL 16'h03A0  control; any write starts a multiply (W)
//  ADDR_GPIN 16'h03A8  latched gpio_in snapshot (R)
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  n_reset         in   1   asynchronous reset, ACTIVE-HIGH (1 = reset), name kept per codebase
//  saddress        in   16  bus address
//  srd             in   1   read strobe (level, may be asynchronous to clk)
//  swr             in   1   write strobe (level, may be asynchronous to clk)
//  sdata_in        in   32  write data
//  sdata_out       out  32  read data
//  gpio_in         in   32  GPIO input pins
//  gpio_latch      in   1   capture strobe for gpio_in
//  gpio_out        out  32  GPIO output pins
//  gpio_in_s_insp  out  32  inspection copy of latched gpio_in
// BEHAVIOUR
//  - Reset (async, n_reset=1): A1, A2, product, status, sdata_out, gpio_out, gpio_in_s_insp, sync flops all 0; FSM -> IDLE.
//  - srd, swr, gpio_latch: 2-FF synchroniser + rising-edge detect; one action per rising edge.
//  - saddress/sdata_in sampled in the cycle the synchronised swr edge is detected; they must be stable >=3 clk before the strobe.
//  - Write A1/A2: register loads full 32 bits; allowed while busy, does not disturb the running multiply.
//  - Write CTRL in IDLE/DONE: copy A1,A2 to working regs, clear product, busy=1, done=0, FSM -> RUN.
//  - Write CTRL while busy: ignored.
//  - Write to any other address: ignored.
//  - RUN: radix-256 shift-add, 4 cycles; cycle k adds (A * B[8k+7:8k]) << 8k into a 64-bit accumulator.
//  - After 4th cycle: product register valid, busy=0, done=1, gpio_out <= product[31:0], FSM -> DONE.
//  - Start-to-done latency: 4 clk after edge detect (<= 6 clk after swr rise incl. sync).
//  - Arithmetic unsigned, no overflow/saturation; full 64-bit product kept, upper half at ADDR_RESH.
//  - Read: on synchronised srd edge, sdata_out <= addressed register (RES/RESH hold last completed product, 0 while busy); unmapped -> 0.
//  - sdata_out holds its value until the next read edge or reset.
//  - gpio_latch rising edge: gpio_in_s_insp <= gpio_in; readable at ADDR_GPIN.
//  - Reset mid-operation aborts the multiply; all outputs return to 0.
// TESTING
//  - Reset pulse -> all outputs 0, status 0, A1/A2 read back 0.
//  - A1=2, A2=8, write CTRL, wait 8 clk -> RES=0x00000010, RESH=0, status=0b10, gpio_out=0x10.
//  - A1=0x10, A2=0x80, start -> RES=0x00000800, gpio_out=0x800.
//  - A1=0x00080000, A2=0x00008007, start -> RESH=0x00000004, RES=0x00380000 (64-bit 0x4_0038_0000).
//  - A1=A2=0xFFFFFFFF -> RESH=0xFFFFFFFE, RES=0x00000001; second CTRL write while busy ignored; A1 write while busy leaves result unchanged.
//  - gpio_in=0xA5A5_5A5A, pulse gpio_latch -> gpio_in_s_insp and read of ADDR_GPIN = 0xA5A55A5A; reset asserted during RUN -> status 0, RES 0.

Source files
------------

// File: rtl/gpio_emu_mul.sv
// Memory-mapped 32x32 unsigned multiplier slave on the emulated GPIO/system bus.
// Bus strobes are synchronised and edge-detected, and the product is built radix-256 over 4 cycles.
module gpio_emu_mul #(
    parameter logic [15:0] ADDR_A1   = 16'h037F,
    parameter logic [15:0] ADDR_A2   = 16'h0388,
    parameter logic [15:0] ADDR_RES  = 16'h0390,
    parameter logic [15:0] ADDR_RESH = 16'h0394,
    parameter logic [15:0] ADDR_STAT = 16'h0398,
    parameter logic [15:0] ADDR_CTRL = 16'h03A0,
    parameter logic [15:0] ADDR_GPIN = 16'h03A8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Strobes may arrive asynchronously: {gpio_latch, swr, srd}
    logic [2:0] strobe_raw;
    logic [2:0] strobe_rise;
    logic       rd_rise;
    logic       wr_rise;
    logic       latch_rise;

    assign strobe_raw = {gpio_latch, swr, srd};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk or posedge n_reset) begin
                if (n_reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= strobe_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign strobe_rise[gi] = sync_reg & ~prev_reg;
        end
    endgenerate

    assign rd_rise    = strobe_rise[0];
    assign wr_rise    = strobe_rise[1];
    assign latch_rise = strobe_rise[2];

    state_t      state_reg;
    state_t      state_next;
    logic        start_cmd;
    logic        busy;
    logic        done;
    logic        load_ops;
    logic        finish;

    logic [31:0] a1_reg;
    logic [31:0] a2_reg;
    logic [31:0] op_a_reg;
    logic [31:0] op_b_reg;
    logic [63:0] acc_reg;
    logic [63:0] product_reg;
    logic [1:0]  step_reg;
    logic [31:0] sdata_out_reg;
    logic [31:0] gpio_out_reg;
    logic [31:0] gpio_in_s_insp_reg;

    logic [7:0]  b_byte;
    logic [39:0] partial_prod;
    logic [63:0] partial_shifted;
    logic [63:0] acc_next;
    logic [31:0] rd_data;

    assign start_cmd = wr_rise && (saddress == ADDR_CTRL);

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start_cmd) state_next = ST_RUN;
            ST_RUN:           if (step_reg == 2'd3) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // A start request during RUN is simply dropped.
    always_comb begin
        busy     = (state_reg == ST_RUN);
        done     = (state_reg == ST_DONE);
        load_ops = start_cmd && (state_reg != ST_RUN);
        finish   = (state_reg == ST_RUN) && (step_reg == 2'd3);
    end

    // One 32x8 partial product per cycle, weighted by the byte position of B.
    assign b_byte          = op_b_reg[{step_reg, 3'b000} +: 8];
    assign partial_prod    = {8'b0, op_a_reg} * {32'b0, b_byte};
    assign partial_shifted = {24'b0, partial_prod} << {step_reg, 3'b000};
    assign acc_next        = acc_reg + partial_shifted;

    always_comb begin
        rd_data = 32'b0;
        case (saddress)
            ADDR_A1:   rd_data = a1_reg;
            ADDR_A2:   rd_data = a2_reg;
            ADDR_RES:  rd_data = product_reg[31:0];
            ADDR_RESH: rd_data = product_reg[63:32];
            ADDR_STAT: rd_data = {30'b0, done, busy};
            ADDR_GPIN: rd_data = gpio_in_s_insp_reg;
            default:   rd_data = 32'b0;
        endcase
    end

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            a1_reg             <= 32'b0;
            a2_reg             <= 32'b0;
            op_a_reg           <= 32'b0;
            op_b_reg           <= 32'b0;
            acc_reg            <= 64'b0;
            product_reg        <= 64'b0;
            step_reg           <= 2'd0;
            sdata_out_reg      <= 32'b0;
            gpio_out_reg       <= 32'b0;
            gpio_in_s_insp_reg <= 32'b0;
        end else begin
            if (wr_rise && (saddress == ADDR_A1)) a1_reg <= sdata_in;
            if (wr_rise && (saddress == ADDR_A2)) a2_reg <= sdata_in;

            // Working copies let the host reload A1/A2 while a multiply runs.
            if (load_ops) begin
                op_a_reg    <= a1_reg;
                op_b_reg    <= a2_reg;
                acc_reg     <= 64'b0;
                product_reg <= 64'b0;
                step_reg    <= 2'd0;
            end else if (busy) begin
                acc_reg  <= acc_next;
                step_reg <= step_reg + 2'd1;
                if (finish) begin
                    product_reg  <= acc_next;
                    gpio_out_reg <= acc_next[31:0];
                end
            end

            if (rd_rise)    sdata_out_reg      <= rd_data;
            if (latch_rise) gpio_in_s_insp_reg <= gpio_in;
        end
    end

    assign sdata_out      = sdata_out_reg;
    assign gpio_out       = gpio_out_reg;
    assign gpio_in_s_insp = gpio_in_s_insp_reg;

endmodule

// File: tb/tb_gpio_emu_mul.sv
// Bench for gpio_emu_mul: bus reads queue their expected data and are checked when sdata_out updates.
// Direct pin checks cover gpio_out, the input snapshot and the reset state.
module tb_gpio_emu_mul;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_RES  = 16'h0390;
    localparam logic [15:0] ADDR_RESH = 16'h0394;
    localparam logic [15:0] ADDR_STAT = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_GPIN = 16'h03A8;

    logic        clk;
    logic        n_reset;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    gpio_emu_mul dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t item;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
    endtask

    task automatic sb_pop_check(input logic [31:0] got);
        sb_item_t item;
        item = sb_q.pop_front();
        check(item.tag, got, item.exp);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        saddress = addr;
        sdata_in = data;
        repeat (3) @(negedge clk);
        swr = 1'b1;
        repeat (4) @(negedge clk);
        swr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        saddress = addr;
        repeat (3) @(negedge clk);
        sb_push(tag, exp);
        srd = 1'b1;
        repeat (4) @(negedge clk);
        sb_pop_check(sdata_out);
        srd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        bus_write(ADDR_A1, a);
        bus_write(ADDR_A2, b);
        bus_write(ADDR_CTRL, 32'h0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset    = 1'b1;
        saddress   = 16'h0;
        srd        = 1'b0;
        swr        = 1'b0;
        sdata_in   = 32'h0;
        gpio_in    = 32'h0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sdata_out", sdata_out, 32'h0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_gpio_insp", gpio_in_s_insp, 32'h0);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        bus_read("rst_a1", ADDR_A1, 32'h0);
        bus_read("rst_a2", ADDR_A2, 32'h0);
        bus_read("rst_stat", ADDR_STAT, 32'h0);
        bus_read("rst_res", ADDR_RES, 32'h0);

        run_mul(32'h2, 32'h8);
        bus_read("m1_res", ADDR_RES, 32'h00000010);
        bus_read("m1_resh", ADDR_RESH, 32'h0);
        bus_read("m1_stat", ADDR_STAT, 32'h2);
        check("m1_gpio_out", gpio_out, 32'h10);

        run_mul(32'h10, 32'h80);
        bus_read("m2_res", ADDR_RES, 32'h00000800);
        check("m2_gpio_out", gpio_out, 32'h800);

        run_mul(32'h00080000, 32'h00008007);
        bus_read("m3_res", ADDR_RES, 32'h00380000);
        bus_read("m3_resh", ADDR_RESH, 32'h00000004);
        bus_read("m3_a2", ADDR_A2, 32'h00008007);
        bus_read("m3_ctrl_rd", ADDR_CTRL, 32'h0);
        bus_read("m3_res2", ADDR_RES, 32'h00380000);
        bus_read("m3_unmapped", 16'h0100, 32'h0);
        check("m3_gpio_out", gpio_out, 32'h00380000);

        // Two CTRL edges back to back: the second lands mid-run and must not restart it.
        bus_write(ADDR_A1, 32'hFFFFFFFF);
        bus_write(ADDR_A2, 32'hFFFFFFFF);
        saddress = ADDR_CTRL;
        repeat (3) @(negedge clk);
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        @(negedge clk);
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        repeat (4) @(negedge clk);
        check("m4_gpio_done_t", gpio_out, 32'h00000001);
        repeat (4) @(negedge clk);
        bus_read("m4_res", ADDR_RES, 32'h00000001);
        bus_read("m4_resh", ADDR_RESH, 32'hFFFFFFFE);
        bus_read("m4_stat", ADDR_STAT, 32'h2);

        // A1 rewritten while the multiply is running.
        saddress = ADDR_CTRL;
        repeat (3) @(negedge clk);
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        repeat (2) @(negedge clk);
        saddress = ADDR_A1;
        sdata_in = 32'h00000003;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        repeat (8) @(negedge clk);
        bus_read("m5_res", ADDR_RES, 32'h00000001);
        bus_read("m5_resh", ADDR_RESH, 32'hFFFFFFFE);
        bus_read("m5_a1", ADDR_A1, 32'h00000003);

        gpio_in = 32'hA5A55A5A;
        repeat (2) @(negedge clk);
        gpio_latch = 1'b1;
        repeat (4) @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in = 32'h12345678;
        repeat (2) @(negedge clk);
        check("gp_insp", gpio_in_s_insp, 32'hA5A55A5A);
        bus_read("gp_read", ADDR_GPIN, 32'hA5A55A5A);

        // Start, read STAT while running, then reset before completion.
        bus_write(ADDR_A1, 32'h00000005);
        saddress = ADDR_CTRL;
        repeat (3) @(negedge clk);
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        repeat (2) @(negedge clk);
        saddress = ADDR_STAT;
        sb_push("rr_stat_busy", 32'h1);
        srd = 1'b1;
        repeat (3) @(negedge clk);
        sb_pop_check(sdata_out);
        n_reset = 1'b1;
        #1;
        check("rr_sdata_out", sdata_out, 32'h0);
        check("rr_gpio_out", gpio_out, 32'h0);
        check("rr_gpio_insp", gpio_in_s_insp, 32'h0);
        srd = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b0;
        repeat (8) @(negedge clk);
        bus_read("rr_stat", ADDR_STAT, 32'h0);
        bus_read("rr_res", ADDR_RES, 32'h0);
        bus_read("rr_a1", ADDR_A1, 32'h0);
        check("rr_gpio_out_late", gpio_out, 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
